// File: rtl/divider4_iter.sv
// Iterative restoring divider: one quotient bit per clock, MSB first.
// Results are registered and held until the next completed division.
module divider4_iter #(
    parameter int width = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(width + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [width-1:0] dvd_q, dvd_d;
    logic [width-1:0] dvs_q, dvs_d;
    logic [width-1:0] rem_q, rem_d;
    logic [width-1:0] quo_q, quo_d;
    logic [width-1:0] quotient_q, quotient_d;
    logic [width-1:0] remainder_q, remainder_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [width:0]   partial_s;
    logic             q_bit_s;
    logic [width-1:0] rem_step_s;
    logic [width-1:0] quo_step_s;

    // One restoring step on the working registers
    always_comb begin
        partial_s = {rem_q, dvd_q[width-1]};
        if (partial_s >= {1'b0, dvs_q}) begin
            q_bit_s    = 1'b1;
            // Difference is below the divisor, so it fits in width bits
            rem_step_s = partial_s[width-1:0] - dvs_q;
        end else begin
            q_bit_s    = 1'b0;
            rem_step_s = partial_s[width-1:0];
        end
        quo_step_s = {quo_q[width-2:0], q_bit_s};
    end

    // Next-state, working datapath and result registers
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        dbz_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    rem_d = {width{1'b0}};
                    quo_d = {width{1'b0}};
                    if (divisor != {width{1'b0}}) begin
                        state_d = RUN;
                        count_d = CW'(width);
                    end else begin
                        state_d     = DONE;
                        done_d      = 1'b1;
                        dbz_d       = 1'b1;
                        quotient_d  = {width{1'b1}};
                        remainder_d = dividend;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                dvd_d   = {dvd_q[width-2:0], 1'b0};
                rem_d   = rem_step_s;
                quo_d   = quo_step_s;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    quotient_d  = quo_step_s;
                    remainder_d = rem_step_s;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= {CW{1'b0}};
            dvd_q       <= {width{1'b0}};
            dvs_q       <= {width{1'b0}};
            rem_q       <= {width{1'b0}};
            quo_q       <= {width{1'b0}};
            quotient_q  <= {width{1'b0}};
            remainder_q <= {width{1'b0}};
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider4_iter.sv
// Bench for divider4_iter: directed cases, reset/busy corner cases, random
// operations and a full operand sweep checked against plain / and %.
module tb_divider4_iter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    divider4_iter #(.width(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs must stay quiet and hold the last result while idle
    task automatic idle_check(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            check("idle_done", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_dbz", 32'(div_by_zero), 32'd0);
            check("idle_quot_hold", 32'(quotient), 32'(last_q));
            check("idle_rem_hold", 32'(remainder), 32'(last_r));
        end
    endtask

    // Start one division; optionally re-pulse start while busy after edge 'inject'
    task automatic run_div(input int a, input int b, input int inject);
        int   n;
        int   busy_n;
        int   exp_n;
        logic seen;
        int   exp_q;
        int   exp_r;
        @(negedge clk);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        n = 0; busy_n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            start    = 1'b0;
            dividend = W'($urandom);
            divisor  = W'($urandom);
            if (n == inject) begin
                start    = 1'b1;
                dividend = W'(15);
                divisor  = W'(5);
            end
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
            end else begin
                check("run_quot_hold", 32'(quotient), 32'(last_q));
                check("run_rem_hold", 32'(remainder), 32'(last_r));
                check("run_dbz_low", 32'(div_by_zero), 32'd0);
            end
        end
        start = 1'b0;
        exp_n = (b == 0) ? 1 : W + 1;
        exp_q = (b == 0) ? (1 << W) - 1 : a / b;
        exp_r = (b == 0) ? a : a % b;
        check("latency", 32'(n), 32'(exp_n));
        check("busy_cycles", 32'(busy_n), 32'(exp_n));
        check("quotient", 32'(quotient), 32'(exp_q));
        check("remainder", 32'(remainder), 32'(exp_r));
        check("div_by_zero", 32'(div_by_zero), (b == 0) ? 32'd1 : 32'd0);
        if (b != 0) begin
            check("identity", 32'((int'(quotient) * b + int'(remainder) == a) && (int'(remainder) < b)), 32'd1);
        end
        last_q = W'(exp_q);
        last_r = W'(exp_r);
        idle_check(1);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        check("rst_quot", 32'(quotient), 32'd0);
        check("rst_rem", 32'(remainder), 32'd0);
        rst = 1'b0;

        run_div(13, 3, 0);
        run_div(15, 1, 0);
        run_div(2, 7, 0);
        run_div(9, 0, 0);

        // Start while busy is ignored and not queued
        run_div(13, 3, 2);
        idle_check(8);

        // Reset mid-run: no done, outputs cleared, next start works
        @(negedge clk);
        start = 1'b1; dividend = W'(13); divisor = W'(3);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_rst_busy", 32'(busy), 32'd0);
        check("midrun_rst_done", 32'(done), 32'd0);
        check("midrun_rst_quot", 32'(quotient), 32'd0);
        check("midrun_rst_rem", 32'(remainder), 32'd0);
        check("midrun_rst_dbz", 32'(div_by_zero), 32'd0);
        last_q = '0;
        last_r = '0;
        idle_check(3);
        run_div(6, 4, 0);

        // Reset wins over start in the same cycle
        @(negedge clk);
        rst = 1'b1; start = 1'b1; dividend = W'(9); divisor = W'(0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", 32'(busy), 32'd0);
        check("rst_prio_done", 32'(done), 32'd0);
        last_q = '0;
        last_r = '0;
        idle_check(2);

        for (int i = 0; i < 20; i++) begin
            run_div(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 0);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(a, b, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divider4_iter.md
DIVIDER4_ITER -- requirements
Module: divider4_iter

Interface
REQ-001 The block SHALL have parameter width, default 4, giving the operand width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  width  unsigned dividend; sampled when start is accepted.
REQ-006 divisor  input  width  unsigned divisor; sampled when start is accepted.
REQ-007 busy  output  1  high while in RUN or DONE.
REQ-008 done  output  1  one-cycle pulse; results valid.
REQ-009 quotient  output  width  unsigned quotient.
REQ-010 remainder  output  width  unsigned remainder.
REQ-011 div_by_zero  output  1  high with done when the captured divisor was 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 at an edge: capture operands; if divisor!=0, go to RUN with the bit counter set to width; else go to DONE.
REQ-014 IDLE with start=0: remain in IDLE; all outputs hold.
REQ-015 RUN: restoring division, one quotient bit per edge, MSB first.
REQ-016 RUN step: partial remainder (width+1 bits) = {rem, next dividend bit}; if >= divisor, subtract and shift in 1, else shift in 0.
REQ-017 RUN SHALL last exactly width edges; after the last step, go to DONE.
REQ-018 DONE: done=1 for exactly one cycle; quotient and remainder valid; next edge goes to IDLE unconditionally.
REQ-019 Latency: for divisor!=0, start accepted at edge E0 -> done high in the cycle after edge E(width+1); for width=4, 5 edges.
REQ-020 Divide by zero: start accepted at E0 -> done high after E1; quotient = all ones; remainder = dividend; div_by_zero=1.
REQ-021 div_by_zero SHALL be high only during the done cycle; it is 0 otherwise.
REQ-022 quotient and remainder SHALL hold their last result until the next DONE; they SHALL NOT show intermediate values during RUN.
REQ-023 start while busy=1 SHALL be ignored; it is neither queued nor able to corrupt the operation in progress.
REQ-024 Operand inputs SHALL NOT affect the result after capture.
REQ-025 The datapath SHALL never overflow: remainder < divisor; quotient*divisor+remainder == dividend (both unsigned).
REQ-026 busy = (state != IDLE), combinationally from state.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE regardless of state, including mid-RUN and DONE.
REQ-028 Reset values: busy=0, done=0, div_by_zero=0, quotient=0, remainder=0, counter=0.
REQ-029 An operation interrupted by reset SHALL produce no done pulse; the first start after reset deasserts SHALL be accepted normally.
REQ-030 rst SHALL take priority over start in the same cycle.

Verification (width=4)
REQ-031 dividend=13, divisor=3, start pulse -> done after 5 edges, quotient=4, remainder=1, div_by_zero=0, busy high for 5 cycles.
REQ-032 dividend=15, divisor=1 -> quotient=15, remainder=0; dividend=2, divisor=7 -> quotient=0, remainder=2.
REQ-033 dividend=9, divisor=0 -> done after 1 edge, quotient=15, remainder=9, div_by_zero=1.
REQ-034 Start 13/3; at edge 2 drive start=1 with 15/5 -> first result 4/1 only; no second done until a fresh start is given in IDLE.
REQ-035 Start 13/3; assert rst at edge 3 -> next cycle busy=0, outputs 0, no done; then 6/4 -> quotient=1, remainder=2.
REQ-036 Exhaustive sweep over all 256 operand pairs -> every result matches the reference division, with 15/dividend/div_by_zero=1 for divisor 0.
